// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Channel-index width; a single channel still needs one bit of index.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational channel arbiter: round-robin from ptr or fixed priority
// (channel 0 highest). While locked, only lock_ch can be granted.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int ARB_MODE = 0,
    parameter int CH_W     = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            lock,
    input  logic [CH_W-1:0] lock_ch,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    int  base;
    int  idx;
    logic found;

    // Pick the first requester at or after base, wrapping; pinned while locked.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        base      = 0;
        idx       = 0;
        if (lock) begin
            for (int i = 0; i < N_CH; i++) begin
                if (CH_W'(i) == lock_ch && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = lock_ch;
                end
            end
        end else begin
            base = (ARB_MODE == int'(ARB_FIXED)) ? 0 : int'(ptr);
            if (base >= N_CH) begin
                base = 0;
            end
            for (int off = 0; off < N_CH; off++) begin
                idx = base + off;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (i == idx && !found && req[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = CH_W'(i);
                        found     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with packet lock and a
// registered output stage.
//
// state       | meaning
// ST_UNLOCKED | between packets, arbiter free to pick any requester
// ST_LOCKED   | mid-packet, grant pinned to lock_ch until its last beat
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int W        = 8,
    parameter  int ARB_MODE = 0,
    localparam int CH_W     = clog2_min1(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready
);

    lock_state_t     state_q, state_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_any;
    logic            load_en;
    logic            accept;
    logic            lock;
    logic [W-1:0]    sel_data;
    logic            sel_last;
    int              nxt_ptr;

    assign lock    = (state_q == ST_LOCKED);
    assign load_en = !out_valid || out_ready;
    assign gnt_any = |grant;
    assign accept  = load_en && gnt_any;
    // out_ready reaches in_ready combinationally so the stage can refill
    // in the same cycle it drains.
    assign in_ready = load_en ? grant : '0;

    rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE),
        .CH_W     (CH_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .lock      (lock),
        .lock_ch   (lock_ch_q),
        .grant     (grant),
        .grant_idx (gnt_idx)
    );

    // Route the granted channel's data and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == CH_W'(i)) begin
                sel_data = in_data[i*W +: W];
                sel_last = in_last[i];
            end
        end
    end

    // Packet-lock next state and round-robin pointer advance.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        nxt_ptr   = 0;
        case (state_q)
            ST_UNLOCKED: begin
                if (accept && !sel_last) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = gnt_idx;
                end
            end
            ST_LOCKED: begin
                if (accept && sel_last) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        if (ARB_MODE == int'(ARB_RR) && accept && sel_last) begin
            nxt_ptr = int'(gnt_idx) + 1;
            if (nxt_ptr >= N_CH) begin
                nxt_ptr = 0;
            end
            rr_ptr_d = CH_W'(nxt_ptr);
        end
    end

    // Lock and pointer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UNLOCKED;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Output stage: refill whenever empty or draining, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_ch   <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: round-robin, fixed-priority and single-channel
// instances, table-driven cycles plus hand-written corner sequences.
module tb_stream_mux_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0]  rr_iv, rr_il, rr_ir;
    logic [31:0] rr_id;
    logic        rr_ov, rr_ol, rr_or;
    logic [7:0]  rr_od;
    logic [1:0]  rr_oc;

    logic [3:0]  fp_iv, fp_il, fp_ir;
    logic [31:0] fp_id;
    logic        fp_ov, fp_ol, fp_or;
    logic [7:0]  fp_od;
    logic [1:0]  fp_oc;

    logic [0:0]  one_iv, one_il, one_ir;
    logic [15:0] one_id, one_od;
    logic        one_ov, one_ol, one_or;
    logic [0:0]  one_oc;

    stream_mux_arb #(.N_CH(4), .W(8), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(rr_iv), .in_data(rr_id),
        .in_last(rr_il), .in_ready(rr_ir), .out_valid(rr_ov),
        .out_data(rr_od), .out_last(rr_ol), .out_ch(rr_oc), .out_ready(rr_or)
    );

    stream_mux_arb #(.N_CH(4), .W(8), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(fp_iv), .in_data(fp_id),
        .in_last(fp_il), .in_ready(fp_ir), .out_valid(fp_ov),
        .out_data(fp_od), .out_last(fp_ol), .out_ch(fp_oc), .out_ready(fp_or)
    );

    stream_mux_arb #(.N_CH(1), .W(16), .ARB_MODE(0)) dut_one (
        .clk(clk), .rst_n(rst_n), .in_valid(one_iv), .in_data(one_id),
        .in_last(one_il), .in_ready(one_ir), .out_valid(one_ov),
        .out_data(one_od), .out_last(one_ol), .out_ch(one_oc), .out_ready(one_or)
    );

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       ordy;
        logic [3:0] rdy;
        logic       exp_ov;
    } vec_t;

    beat_t       rr_q[$];
    logic [15:0] one_q[$];
    beat_t       rr_b;
    logic [15:0] one_b;
    vec_t        rows[20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] lane(input int ch, input int tag);
        return 8'((ch << 4) | (tag & 15));
    endfunction

    task automatic drive_rr(input logic [3:0] v, input logic [3:0] l, input logic ordy, input int tag);
        rr_iv = v;
        rr_il = l;
        rr_or = ordy;
        for (int i = 0; i < 4; i++) rr_id[i*8 +: 8] = lane(i, tag);
    endtask

    task automatic push_rr(input logic [3:0] v, input logic [3:0] rdy, input logic [3:0] l, input int tag);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && rdy[i]) begin
                b.ch   = 2'(i);
                b.data = lane(i, tag);
                b.last = l[i];
                rr_q.push_back(b);
            end
        end
    endtask

    task automatic push_one_beat(input logic [1:0] ch, input logic [7:0] d, input logic l);
        beat_t b;
        b.ch   = ch;
        b.data = d;
        b.last = l;
        rr_q.push_back(b);
    endtask

    // Scoreboard for the round-robin instance: compare every output handshake.
    always @(negedge clk) begin
        if (rst_n && rr_ov && rr_or) begin
            if (rr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rr_extra_beat actual ch=%0d data=%0h required=no beat", rr_oc, rr_od);
            end else begin
                rr_b = rr_q.pop_front();
                check("rr_out_ch", 32'(rr_oc), 32'(rr_b.ch));
                check("rr_out_data", 32'(rr_od), 32'(rr_b.data));
                check("rr_out_last", 32'(rr_ol), 32'(rr_b.last));
            end
        end
    end

    // Scoreboard for the single-channel instance.
    always @(negedge clk) begin
        if (rst_n && one_ov && one_or) begin
            if (one_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL one_extra_beat actual data=%0h required=no beat", one_od);
            end else begin
                one_b = one_q.pop_front();
                check("one_out_data", 32'(one_od), 32'(one_b));
                check("one_out_ch", 32'(one_oc), 32'd0);
            end
        end
    end

    initial begin
        // v, last, out_ready, expected in_ready, expected out_valid after edge
        rows[0] = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1};
        rows[1] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1};
        rows[2] = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1};
        rows[3] = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1};
        rows[4] = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1};
        rows[5] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1};
        for (int r = 6; r <= 10; r++) rows[r] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1};
        rows[11] = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1};
        rows[12] = '{4'h4, 4'h0, 1'b1, 4'h4, 1'b1};
        rows[13] = '{4'h5, 4'h0, 1'b1, 4'h4, 1'b1};
        rows[14] = '{4'h1, 4'h0, 1'b1, 4'h0, 1'b0};
        rows[15] = '{4'h1, 4'h0, 1'b1, 4'h0, 1'b0};
        rows[16] = '{4'h5, 4'h4, 1'b1, 4'h4, 1'b1};
        rows[17] = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b1};
        rows[18] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0};
        rows[19] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};

        drive_rr(4'h0, 4'h0, 1'b0, 0);
        fp_iv = '0; fp_il = '0; fp_id = '0; fp_or = 1'b0;
        one_iv = '0; one_il = '0; one_id = '0; one_or = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(rr_ov), 32'd0);
        check("rst_out_data", 32'(rr_od), 32'd0);
        check("rst_out_last", 32'(rr_ol), 32'd0);
        check("rst_out_ch", 32'(rr_oc), 32'd0);
        check("rst_fp_out_valid", 32'(fp_ov), 32'd0);
        check("rst_one_out_valid", 32'(one_ov), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fairness, backpressure, packet lock with a valid gap, idle.
        for (int r = 0; r < 20; r++) begin
            if (r > 0) check("tbl_out_valid", 32'(rr_ov), 32'(rows[r-1].exp_ov));
            drive_rr(rows[r].v, rows[r].l, rows[r].ordy, r);
            #1;
            check("tbl_in_ready", 32'(rr_ir), 32'(rows[r].rdy));
            push_rr(rows[r].v, rows[r].rdy, rows[r].l, r);
            @(posedge clk);
            #1;
        end
        check("tbl_out_valid", 32'(rr_ov), 32'(rows[19].exp_ov));

        // Reset mid-packet: ch1 locked with a held beat.
        drive_rr(4'h2, 4'h0, 1'b1, 0);
        #1;
        check("mid_in_ready", 32'(rr_ir), 32'h2);
        @(posedge clk);
        #1;
        rr_or = 1'b0;
        check("mid_out_valid", 32'(rr_ov), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(rr_ov), 32'd0);
        check("async_rst_out_ch", 32'(rr_oc), 32'd0);
        check("async_rst_out_data", 32'(rr_od), 32'd0);
        drive_rr(4'hF, 4'hF, 1'b1, 0);
        @(posedge clk);
        #1;
        check("in_rst_out_valid", 32'(rr_ov), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(rr_ir), 32'h1);
        push_one_beat(2'd0, lane(0, 0), 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_out_ch", 32'(rr_oc), 32'd0);
        check("post_rst_out_valid", 32'(rr_ov), 32'd1);

        // Backpressure: hold 0xA5 for five cycles, then refill same cycle.
        drive_rr(4'h8, 4'h8, 1'b1, 0);
        rr_id[31:24] = 8'hA5;
        #1;
        check("a5_in_ready", 32'(rr_ir), 32'h8);
        push_one_beat(2'd3, 8'hA5, 1'b1);
        @(posedge clk);
        #1;
        check("a5_out_valid", 32'(rr_ov), 32'd1);
        check("a5_out_data", 32'(rr_od), 32'hA5);
        drive_rr(4'hF, 4'hF, 1'b0, 14);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", 32'(rr_ir), 32'h0);
            check("bp_out_data", 32'(rr_od), 32'hA5);
            check("bp_out_valid", 32'(rr_ov), 32'd1);
            @(posedge clk);
            #1;
        end
        rr_or = 1'b1;
        #1;
        check("release_in_ready", 32'(rr_ir), 32'h1);
        push_one_beat(2'd0, lane(0, 14), 1'b1);
        @(posedge clk);
        #1;
        check("release_out_ch", 32'(rr_oc), 32'd0);
        check("release_out_data", 32'(rr_od), 32'(lane(0, 14)));
        drive_rr(4'h0, 4'h0, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;

        // Fixed priority: ch1 starves ch3 until it drops valid.
        fp_iv = 4'b1010;
        fp_il = 4'hF;
        fp_or = 1'b1;
        for (int i = 0; i < 4; i++) fp_id[i*8 +: 8] = lane(i, 1);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("fp_in_ready", 32'(fp_ir), 32'h2);
            @(posedge clk);
            #1;
            check("fp_out_ch", 32'(fp_oc), 32'd1);
            check("fp_out_valid", 32'(fp_ov), 32'd1);
        end
        fp_iv = 4'b1000;
        #1;
        check("fp_ch3_in_ready", 32'(fp_ir), 32'h8);
        @(posedge clk);
        #1;
        check("fp_ch3_out_ch", 32'(fp_oc), 32'd3);
        check("fp_ch3_out_data", 32'(fp_od), 32'(lane(3, 1)));
        fp_iv = 4'b0000;

        // Single channel: plain one-entry pipeline register.
        for (int k = 1; k <= 16; k++) begin
            one_iv = 1'b1;
            one_id = 16'(k);
            one_il = 1'((k % 4) == 0);
            one_or = 1'b1;
            #1;
            check("one_in_ready", 32'(one_ir), 32'd1);
            one_q.push_back(16'(k));
            @(posedge clk);
            #1;
            check("one_latency_data", 32'(one_od), 32'(k));
            check("one_out_valid", 32'(one_ov), 32'd1);
        end
        one_iv = 1'b0;
        @(posedge clk);
        #1;
        check("one_drained", 32'(one_ov), 32'd0);
        @(posedge clk);
        #1;

        check("rr_queue_empty", 32'(rr_q.size()), 32'd0);
        check("one_queue_empty", 32'(one_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel streaming multiplexer; successor to the 2:1 mux primitive.
- Selects one of N_CH valid/ready input streams using round-robin or fixed-priority arbitration.
- Holds the selection for a whole packet (until `last`) and drives a registered output stage.
- Sits between producer channels and a shared downstream consumer (e.g. display/UART/sound sink).

Parameters:
- N_CH, 4, number of input channels (>=1)
- W, 8, data width per beat
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
- CH_W, max(1,$clog2(N_CH)), width of channel-index output (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_CH  per-channel beat valid
- in_data  input  N_CH*W  flattened data, channel i at [i*W +: W]
- in_last  input  N_CH  per-channel end-of-packet flag
- in_ready  output  N_CH  per-channel accept, at most one bit high
- out_valid  output  1  registered output beat valid
- out_data  output  W  registered output data
- out_last  output  1  registered end-of-packet flag
- out_ch  output  CH_W  source channel of current output beat
- out_ready  input  1  downstream accept

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=0, lock=0, lock_ch=0.
- Reset mid-packet discards the held beat and the lock; no beat is emitted after reset until a new grant.
- load_en = !out_valid | out_ready. When load_en, the output register loads the granted channel.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle while out_ready=1.
- Handshake:
  - in_ready[i] = load_en & grant[i].
  - Input beat transfers when in_valid[i] & in_ready[i].
  - Output beat transfers when out_valid & out_ready.
  - While out_valid & !out_ready, out_data/out_last/out_ch are held stable.
- Arbitration (combinational, only when lock=0):
  - ARB_MODE=0: first valid channel searching from rr_ptr upward, wrapping N_CH-1 -> 0.
  - ARB_MODE=1: lowest valid index.
  - No valid channels: grant=0, out_valid clears on the next load_en.
- Packet lock, two states:
  - UNLOCKED -> LOCKED(lock_ch=g) on an accepted beat with in_last=0.
  - LOCKED -> UNLOCKED on an accepted beat from lock_ch with in_last=1.
  - A single-beat packet (last=1 on first beat) never enters LOCKED.
  - While LOCKED, grant = lock_ch only. If that channel drops in_valid, bubbles are inserted and no other channel is served.
- rr_ptr update: on an accepted beat with in_last=1, rr_ptr <= (granted+1) mod N_CH. Unchanged otherwise, and unchanged in ARB_MODE=1.
- N_CH=1: grant is always channel 0, out_ch=0, behaves as a one-entry pipeline register.
- Same-cycle input acceptance and output drain are allowed (full throughput); no combinational path from in_valid to out_valid.
- Combinational path out_ready -> in_ready exists and is accepted by design.

Decomposition:
- Package stream_mux_pkg:
  - arb_mode_t enum (ARB_RR=0, ARB_FIXED=1).
  - Function clog2_min1 for CH_W.
- Sub-module rr_arbiter:
  - Parameters N_CH, ARB_MODE.
  - Inputs: req, ptr, lock, lock_ch.
  - Output: one-hot grant plus encoded index. Purely combinational.
- Data select:
  - Top level uses an N_CH:1 mux indexed by the encoded grant.
  - State and output registers also live in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-packet with out_valid=1 -> out_valid=0, out_ch=0 immediately (async). After release, first grant goes to ch0 if all valid.
- Round-robin fairness: N_CH=4, ARB_MODE=0, all channels valid with single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0,1, one beat per cycle after 1-cycle latency.
- Packet lock: ch2 sends 3 beats (last on beat 3), ch0 valid throughout -> out_ch=2,2,2 then 0. ch2 valid gap of 2 cycles mid-packet -> 2 bubbles, ch0 not granted.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1, data 0xA5 -> out_data stays 0xA5, in_ready all 0. out_ready=1 -> next beat loads same cycle.
- Fixed priority: ARB_MODE=1, ch1 and ch3 continuously valid with single-beat packets -> only ch1 served. ch1 drops valid -> ch3 served next cycle.
- Degenerate: N_CH=1, W=16, continuous stream 0x0001..0x0010 with out_ready=1 -> identical sequence out, 1-cycle delay, out_ch=0.
